// File: rtl/sprite_orient_pipe_pkg.sv
// ---------------------------------------------------------------------------
// sprite_pkg : orientation codes, stream field bounds and the address helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sprite_pkg;

    localparam logic [2:0] RIGHT        = 3'b000;
    localparam logic [2:0] DOWN         = 3'b001;
    localparam logic [2:0] UP           = 3'b010;
    localparam logic [2:0] LEFT         = 3'b011;
    localparam logic [2:0] RIGHT_MIRROR = 3'b100;
    localparam logic [2:0] DOWN_MIRROR  = 3'b101;
    localparam logic [2:0] UP_MIRROR    = 3'b110;
    localparam logic [2:0] LEFT_MIRROR  = 3'b111;

    localparam int COORD_W = 10;
    localparam int XC_HI   = 22;
    localparam int XC_LO   = 13;
    localparam int YC_HI   = 12;
    localparam int YC_LO   = 3;
    localparam int COL_HI  = 25;
    localparam int COL_LO  = 23;

    // Returns {A, B} packed into the low 2*n bits; coordinates up to 8 bits.
    function automatic logic [15:0] orient_addr(input logic [2:0] code,
                                                input logic [7:0] px,
                                                input logic [7:0] py,
                                                input int         n);
        logic [7:0] mask;
        logic [7:0] npx;
        logic [7:0] npy;
        logic [7:0] a;
        logic [7:0] b;
        mask = 8'((16'd1 << n) - 16'd1);
        npx  = ~px & mask;
        npy  = ~py & mask;
        a    = py;
        b    = npx;
        case (code)
            RIGHT:        begin a = py;  b = npx; end
            DOWN:         begin a = px;  b = py;  end
            UP:           begin a = px;  b = npy; end
            LEFT:         begin a = py;  b = px;  end
            RIGHT_MIRROR: begin a = npy; b = npx; end
            DOWN_MIRROR:  begin a = npx; b = py;  end
            UP_MIRROR:    begin a = npx; b = npy; end
            LEFT_MIRROR:  begin a = npy; b = px;  end
        endcase
        orient_addr = (16'(a) << n) | 16'(b);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_orient_pipe_if.sv
// ---------------------------------------------------------------------------
// sprite_orient_pipe_if : pixel stream, sprite control and bitmap ROM bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sprite_orient_pipe_if #(
    parameter int STR_W  = 26,
    parameter int ADDR_W = 11
);
    logic [STR_W-1:0]  RGBStr_i;
    logic [9:0]        posx_i;
    logic [9:0]        posy_i;
    logic [7:0]        sprite;
    logic              spr_en_i;
    logic [ADDR_W-1:0] addr;
    logic              rom_data_i;
    logic              inside_o;
    logic [STR_W-1:0]  RGBStr_o;

    modport master (
        output RGBStr_i, posx_i, posy_i, sprite, spr_en_i, rom_data_i,
        input  addr, inside_o, RGBStr_o
    );

    modport slave (
        input  RGBStr_i, posx_i, posy_i, sprite, spr_en_i, rom_data_i,
        output addr, inside_o, RGBStr_o
    );
endinterface

`default_nettype wire

// File: rtl/sprite_orient_pipe_stream_delay.sv
// ---------------------------------------------------------------------------
// stream_delay : WIDTH x DEPTH shift register with synchronous clear
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stream_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = i_data;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign o_data = stage_q[DEPTH-1];
endmodule

`default_nettype wire

// File: rtl/sprite_orient_pipe.sv
// ---------------------------------------------------------------------------
// sprite_orient_pipe : frame-latched sprite window, oriented ROM address and
// stream composite. Optional SPRITE_SCALE2X_EN doubles each texel to 2x2.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sprite_orient_pipe
    import sprite_pkg::*;
#(
    parameter int STR_W    = 26,
    parameter int SPR_LOG2 = 4,
    parameter int BMP_BITS = 3,
    parameter int ROM_LAT  = 1
) (
    input  logic                px_clk,
    input  logic                reset,
    sprite_orient_pipe_if.slave bus
);
    localparam int ADDR_W = BMP_BITS + 2*SPR_LOG2;
`ifdef SPRITE_SCALE2X_EN
    localparam int SCALE_SH = 1;
`else
    localparam int SCALE_SH = 0;
`endif
    localparam int               WIN_LOG2 = SPR_LOG2 + SCALE_SH;
    localparam logic [COORD_W:0] WIN_SIZE = (COORD_W+1)'(2**WIN_LOG2);

    logic [COORD_W-1:0]  x_s, y_s, rx, ry;
    logic                frame_start;
    logic [COORD_W-1:0]  lposx_q, lposx_d, lposy_q, lposy_d;
    logic [2:0]          lorient_q, lorient_d;
    logic [BMP_BITS-1:0] lbmp_q, lbmp_d;
    logic                len_q, len_d;
    logic                in1_q, in1_d;
    logic [SPR_LOG2-1:0] px1_q, px1_d, py1_q, py1_d;
    logic [2:0]          orient1_q, orient1_d;
    logic [BMP_BITS-1:0] bmp1_q, bmp1_d;
    logic [15:0]         oa;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                inside_q, inside_d;
    logic [STR_W-1:0]    rgb_q, rgb_d;
    logic [STR_W-1:0]    dly_str;
    logic                dly_in;
    logic                unused_bits;

    assign x_s         = bus.RGBStr_i[XC_HI:XC_LO];
    assign y_s         = bus.RGBStr_i[YC_HI:YC_LO];
    assign frame_start = (x_s == '0) && (y_s == '0);
    assign rx          = x_s - lposx_q;
    assign ry          = y_s - lposy_q;
    assign oa          = orient_addr(orient1_q, 8'(px1_q), 8'(py1_q), SPR_LOG2);
    assign unused_bits = ^{oa, bus.sprite};

    always_comb begin
        lposx_d   = lposx_q;
        lposy_d   = lposy_q;
        lorient_d = lorient_q;
        lbmp_d    = lbmp_q;
        len_d     = len_q;
        // Shadow copy only at the frame origin so a moving sprite never tears.
        if (frame_start) begin
            lposx_d   = bus.posx_i;
            lposy_d   = bus.posy_i;
            lorient_d = bus.sprite[7:5];
            lbmp_d    = bus.sprite[BMP_BITS-1:0];
            len_d     = bus.spr_en_i;
        end

        // Negative offsets wrap to large values and fail the unsigned compare.
        in1_d     = len_q && ({1'b0, rx} < WIN_SIZE) && ({1'b0, ry} < WIN_SIZE);
        px1_d     = rx[SCALE_SH +: SPR_LOG2];
        py1_d     = ry[SCALE_SH +: SPR_LOG2];
        orient1_d = lorient_q;
        bmp1_d    = lbmp_q;

        addr_d    = {bmp1_q, oa[2*SPR_LOG2-1:0]};
        inside_d  = in1_q;

        rgb_d = dly_str;
        if (dly_in && bus.rom_data_i) begin
            rgb_d[COL_HI:COL_LO] = 3'b111;
        end
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            lposx_q   <= '0;
            lposy_q   <= '0;
            lorient_q <= '0;
            lbmp_q    <= '0;
            len_q     <= 1'b0;
            in1_q     <= 1'b0;
            px1_q     <= '0;
            py1_q     <= '0;
            orient1_q <= '0;
            bmp1_q    <= '0;
            addr_q    <= '0;
            inside_q  <= 1'b0;
            rgb_q     <= '0;
        end else begin
            lposx_q   <= lposx_d;
            lposy_q   <= lposy_d;
            lorient_q <= lorient_d;
            lbmp_q    <= lbmp_d;
            len_q     <= len_d;
            in1_q     <= in1_d;
            px1_q     <= px1_d;
            py1_q     <= py1_d;
            orient1_q <= orient1_d;
            bmp1_q    <= bmp1_d;
            addr_q    <= addr_d;
            inside_q  <= inside_d;
            rgb_q     <= rgb_d;
        end
    end

    // Stream waits for address pipeline plus ROM; inside only waits for ROM.
    stream_delay #(.WIDTH(STR_W), .DEPTH(2 + ROM_LAT)) u_str_dly (
        .clk    (px_clk),
        .rst    (reset),
        .i_data (bus.RGBStr_i),
        .o_data (dly_str)
    );

    stream_delay #(.WIDTH(1), .DEPTH(ROM_LAT)) u_ins_dly (
        .clk    (px_clk),
        .rst    (reset),
        .i_data (inside_q),
        .o_data (dly_in)
    );

    assign bus.addr     = addr_q;
    assign bus.inside_o = inside_q;
    assign bus.RGBStr_o = rgb_q;
endmodule

`default_nettype wire

// File: tb/tb_sprite_orient_pipe.sv
// ---------------------------------------------------------------------------
// tb_sprite_orient_pipe : directed stimulus against a per-cycle reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sprite_orient_pipe;
    import sprite_pkg::*;

    localparam int ROM_LAT = 2;
    localparam int OUT_LAT = 3 + ROM_LAT;
    localparam int MAXC    = 1024;
`ifdef SPRITE_SCALE2X_EN
    localparam int SH = 1;
`else
    localparam int SH = 0;
`endif
    localparam int WIN = 16 << SH;

    logic px_clk = 1'b0;
    logic reset;
    always #5 px_clk = ~px_clk;

    sprite_orient_pipe_if #(.STR_W(26), .ADDR_W(11)) bus ();

    sprite_orient_pipe #(.ROM_LAT(ROM_LAT)) dut (
        .px_clk (px_clk),
        .reset  (reset),
        .bus    (bus.slave)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          rst_at [MAXC];
    bit          rom_at [MAXC];
    bit          ins_at [MAXC];
    int          adr_at [MAXC];
    logic [25:0] str_at [MAXC];
    int          mlx = 0, mly = 0, mor = 0, mbmp = 0;
    bit          men = 1'b0;

    function automatic logic [25:0] mk(input int x, input int y, input int col, input int low);
        return {3'(col), 10'(x), 10'(y), 3'(low)};
    endfunction

    // Orientation table written from the sprite's point of view: u = column, v = row.
    function automatic int exp_addr(input int o, input int bmp, input int u, input int v);
        int a, b;
        case (o)
            0:       begin a = v;      b = 15 - u; end
            1:       begin a = u;      b = v;      end
            2:       begin a = u;      b = 15 - v; end
            3:       begin a = v;      b = u;      end
            4:       begin a = 15 - v; b = 15 - u; end
            5:       begin a = 15 - u; b = v;      end
            6:       begin a = 15 - u; b = 15 - v; end
            default: begin a = 15 - v; b = u;      end
        endcase
        return bmp * 256 + a * 16 + b;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: one entry per sampled input word.
    initial forever begin
        int x, y, dx, dy;
        @(posedge px_clk);
        cyc++;
        if (cyc >= MAXC - 1) begin
            $display("FAIL cycle_budget: got %0d cycles expected < %0d", cyc, MAXC - 1);
            $fatal(1, "cycle budget exhausted");
        end
        x  = int'(bus.RGBStr_i[22:13]);
        y  = int'(bus.RGBStr_i[12:3]);
        dx = (x - mlx) & 1023;
        dy = (y - mly) & 1023;
        rst_at[cyc] = reset;
        rom_at[cyc] = bus.rom_data_i;
        str_at[cyc] = bus.RGBStr_i;
        ins_at[cyc] = men && (dx < WIN) && (dy < WIN);
        adr_at[cyc] = exp_addr(mor, mbmp, (dx >> SH) & 15, (dy >> SH) & 15);
        if (reset) begin
            mlx = 0; mly = 0; mor = 0; mbmp = 0; men = 1'b0;
        end else if (x == 0 && y == 0) begin
            mlx  = int'(bus.posx_i);
            mly  = int'(bus.posy_i);
            mor  = int'(bus.sprite[7:5]);
            mbmp = int'(bus.sprite[2:0]);
            men  = bus.spr_en_i;
        end
    end

    // Compare every cycle against the model.
    initial forever begin
        int          j;
        bit          killed;
        logic [25:0] e;
        @(negedge px_clk);
        if (cyc >= 1) begin
            if (rst_at[cyc]) begin
                check("rst_inside", int'(bus.inside_o), 0);
                check("rst_addr", int'(bus.addr), 0);
            end else if (cyc >= 2 && !rst_at[cyc-1]) begin
                check("inside", int'(bus.inside_o), int'(ins_at[cyc-1]));
                check("addr", int'(bus.addr), adr_at[cyc-1]);
            end else begin
                check("inside_flush", int'(bus.inside_o), 0);
            end
            j      = cyc - (OUT_LAT - 1);
            killed = (j < 1);
            for (int k = (j < 1 ? 1 : j); k <= cyc; k++) begin
                if (rst_at[k]) killed = 1'b1;
            end
            if (killed) begin
                e = '0;
            end else begin
                e = str_at[j];
                if (ins_at[j] && rom_at[cyc]) e[25:23] = 3'b111;
            end
            check("rgb", int'(bus.RGBStr_o), int'(e));
        end
    end

    task automatic step(input logic [25:0] w, input bit rom);
        bus.RGBStr_i   = w;
        bus.rom_data_i = rom;
        @(posedge px_clk);
        #1;
    endtask

    task automatic frame(input int px, input int py, input logic [7:0] spr, input bit en);
        bus.posx_i   = 10'(px);
        bus.posy_i   = 10'(py);
        bus.sprite   = spr;
        bus.spr_en_i = en;
        step(mk(0, 0, 2, 1), 1'b0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.RGBStr_i   = '0;
        bus.posx_i     = '0;
        bus.posy_i     = '0;
        bus.sprite     = '0;
        bus.spr_en_i   = 1'b0;
        bus.rom_data_i = 1'b0;
        repeat (3) step(mk(5, 5, 0, 0), 1'b0);
        reset = 1'b0;
        step(mk(5, 6, 3, 0), 1'b1);

        // RIGHT, bitmap 1, top-left texel
        frame(100, 50, 8'h01, 1'b1);
        step(mk(100, 50, 0, 5), 1'b1);
        step(mk(101, 50, 0, 0), 1'b1);
        check("lit_right_addr", int'(bus.addr), 'h10F);
        check("lit_right_inside", int'(bus.inside_o), 1);
        step(mk(102, 50, 4, 0), 1'b1);
        step(mk(103, 50, 0, 0), 1'b1);
        step(mk(104, 50, 0, 0), 1'b1);
        check("lit_composite", int'(bus.RGBStr_o), int'(mk(100, 50, 7, 5)));

        // LEFT_MIRROR, bottom-right texel then just past the edge
        frame(100, 50, 8'hE1, 1'b1);
        step(mk(115, 65, 1, 2), 1'b0);
        step(mk(116, 65, 1, 2), 1'b0);
        check("lit_lmirror_addr", int'(bus.addr), 'h10F);
        check("lit_lmirror_inside", int'(bus.inside_o), 1);
        step(mk(0, 1, 0, 0), 1'b0);
        check("lit_right_edge", int'(bus.inside_o), 0);

        // Mid-frame position change is ignored until the next origin word
        bus.posx_i = 10'd200;
        step(mk(100, 50, 0, 0), 1'b1);
        step(mk(200, 50, 0, 0), 1'b1);
        check("lit_old_pos_inside", int'(bus.inside_o), 1);
        step(mk(7, 7, 0, 0), 1'b1);
        check("lit_new_pos_pending", int'(bus.inside_o), 0);
        step(mk(0, 0, 0, 0), 1'b1);
        step(mk(200, 50, 0, 0), 1'b1);
        step(mk(100, 50, 0, 0), 1'b1);
        check("lit_new_pos_inside", int'(bus.inside_o), 1);
        step(mk(7, 7, 0, 0), 1'b1);
        check("lit_old_pos_gone", int'(bus.inside_o), 0);

        // Sprite straddling the right edge
        frame(1020, 50, 8'h01, 1'b1);
        step(mk(2, 50, 0, 0), 1'b1);
        step(mk(1019, 50, 0, 0), 1'b1);
        check("lit_wrap_inside", int'(bus.inside_o), 1);
        check("lit_wrap_addr", int'(bus.addr), 'h109);
        step(mk(7, 7, 0, 0), 1'b1);
        check("lit_wrap_left_out", int'(bus.inside_o), 0);

        // Disabled sprite: stream passes untouched
        frame(1020, 50, 8'h01, 1'b0);
        step(mk(1021, 51, 0, 6), 1'b1);
        step(mk(1022, 51, 0, 0), 1'b1);
        check("lit_disabled", int'(bus.inside_o), 0);

        // Every orientation on one off-axis texel
        for (int o = 0; o < 8; o++) begin
            frame(100, 50, {3'(o), 5'd2}, 1'b1);
            step(mk(103, 57, o, o), o[0]);
            step(mk(99, 57, 0, 0), 1'b1);
            step(mk(103, 49, 0, 0), ~o[0]);
        end

        // Reset in mid-stream hides the sprite until the next origin word
        frame(100, 50, 8'h01, 1'b1);
        step(mk(100, 50, 0, 3), 1'b1);
        reset = 1'b1;
        step(mk(100, 50, 0, 3), 1'b1);
        check("lit_rst_addr", int'(bus.addr), 0);
        check("lit_rst_inside", int'(bus.inside_o), 0);
        check("lit_rst_rgb", int'(bus.RGBStr_o), 0);
        reset = 1'b0;
        step(mk(100, 50, 0, 3), 1'b1);
        step(mk(101, 50, 0, 3), 1'b1);
        step(mk(102, 50, 0, 3), 1'b1);
        check("lit_rst_hidden", int'(bus.inside_o), 0);
        frame(100, 50, 8'h01, 1'b1);
        step(mk(131, 50, 0, 0), 1'b1);
        step(mk(100, 50, 0, 0), 1'b1);
`ifdef SPRITE_SCALE2X_EN
        check("lit_scale_inside", int'(bus.inside_o), 1);
        check("lit_scale_addr", int'(bus.addr), 'h100);
`else
        check("lit_far_texel_out", int'(bus.inside_o), 0);
`endif
        step(mk(10, 10, 0, 0), 1'b1);
        check("lit_relatched", int'(bus.inside_o), 1);

        repeat (OUT_LAT + 2) step(mk(20, 20, 5, 5), 1'b1);
        @(negedge px_clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
